// File: rtl/arb_in_buf_pkg.sv
// Shared defaults and payload type for the arbiter input buffer.
// Optional bypass path: define ARB_IN_BUF_BYPASS_EN.
package arb_in_buf_pkg;

  localparam int DEF_NUM_CLIENTS = 4;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH       = 4;

  typedef logic [DEF_DATA_WIDTH-1:0] t_client_data;

endpackage

// File: rtl/arb_in_fifo.sv
// Single-client circular FIFO with occupancy count and sticky pop-on-empty flag.
// Define ARB_IN_BUF_BYPASS_EN for a 0-cycle head bypass when the queue is empty.
module arb_in_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  input  logic                          grant,
  output logic                          valid_candidate,
  output logic [DATA_WIDTH-1:0]         candidate,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic                          err_pop_empty
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  err_q;

  logic full;
  logic empty;
  logic head_valid;
  logic bypass;
  logic push;
  logic pop;
  logic do_write;
  logic do_read;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full       = (wr_ptr ^ rd_ptr) == {1'b1, {(PW-1){1'b0}}};
  assign empty      = (wr_ptr == rd_ptr);
  assign head_valid = !empty && !rst;

`ifdef ARB_IN_BUF_BYPASS_EN
  assign bypass = empty && in_valid && !rst;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready        = !full && !rst;
  assign valid_candidate = head_valid || bypass;
  assign occupancy       = rst ? '0 : count;
  assign err_pop_empty   = err_q && !rst;

  // NOTE: always_comb uses blocking assignments with a default first, so no latch is inferred.
  always_comb begin
    candidate = '0;
    if (head_valid) begin
      candidate = mem[rd_ptr[PW-2:0]];
    end
`ifdef ARB_IN_BUF_BYPASS_EN
    else if (bypass) begin
      candidate = in_data;
    end
`endif
  end

  assign push = in_valid && in_ready;
  assign pop  = grant && valid_candidate;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign do_write = push && !(bypass && pop);
  assign do_read  = pop && head_valid;

  // NOTE: storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[PW-2:0]] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (do_read)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_write, do_read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (grant && !valid_candidate) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/arb_in_buf.sv
// Per-client input queues feeding an arbiter; pops follow the one-hot/multi-hot grant.
// Optional bypass path: define ARB_IN_BUF_BYPASS_EN.
module arb_in_buf
  import arb_in_buf_pkg::*;
#(
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CLIENTS-1:0]                        in_valid,
  input  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]        in_data,
  output logic [NUM_CLIENTS-1:0]                        in_ready,
  output logic [NUM_CLIENTS-1:0]                        valid_candidate,
  output logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]        candidate,
  input  logic [NUM_CLIENTS-1:0]                        winner_dec_id,
  output logic [NUM_CLIENTS-1:0][$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [NUM_CLIENTS-1:0]                        err_pop_empty
);

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    arb_in_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid[i]),
      .in_data         (in_data[i]),
      .in_ready        (in_ready[i]),
      .grant           (winner_dec_id[i]),
      .valid_candidate (valid_candidate[i]),
      .candidate       (candidate[i]),
      .occupancy       (occupancy[i]),
      .err_pop_empty   (err_pop_empty[i])
    );
  end

endmodule

// File: doc/arb_in_buf.md
ARB_IN_BUF -- requirements
Module: arb_in_buf

Interface
REQ-001 The block SHALL take parameter NUM_CLIENTS, default 4, meaning the number of independent input queues, which is also the arbiter candidate count.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, meaning the payload width per client.
REQ-003 The block SHALL take parameter DEPTH, default 4, meaning the entries per queue; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, [NUM_CLIENTS-1:0]: per-client push request.
REQ-007 The block SHALL have port in_data, input, [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]: per-client push payload.
REQ-008 The block SHALL have port in_ready, output, [NUM_CLIENTS-1:0]: per-client queue can accept a push.
REQ-009 The block SHALL have port valid_candidate, output, [NUM_CLIENTS-1:0]: queue head valid, fed to the arbiter.
REQ-010 The block SHALL have port candidate, output, [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]: queue head payload, fed to the arbiter.
REQ-011 The block SHALL have port winner_dec_id, input, [NUM_CLIENTS-1:0]: one-hot grant from the arbiter, used as the pop request.
REQ-012 The block SHALL have port occupancy, output, [NUM_CLIENTS-1:0][$clog2(DEPTH+1)-1:0]: per-queue entry count.
REQ-013 The block SHALL have port err_pop_empty, output, [NUM_CLIENTS-1:0]: sticky flag, grant received while the queue was empty.

Function
REQ-014 Each client SHALL own an independent circular FIFO of DEPTH entries with read/write pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
REQ-015 Full SHALL be defined as pointers differing only in the wrap bit; empty SHALL be defined as pointers equal.
REQ-016 in_ready[i] SHALL equal !full[i] from registered state only; a same-cycle pop SHALL NOT raise in_ready.
REQ-017 A push SHALL occur when in_valid[i] & in_ready[i]; the data is written at the write pointer, and the pointer increments modulo 2*DEPTH.
REQ-018 valid_candidate[i] SHALL equal !empty[i]; candidate[i] SHALL be the head entry when valid, else '0.
REQ-019 A pop SHALL occur when winner_dec_id[i] & valid_candidate[i]; the read pointer increments, and the next head is visible the following cycle.
REQ-020 A grant to an empty queue SHALL be ignored (no pointer change) and SHALL set err_pop_empty[i] until rst.
REQ-021 A multi-hot winner_dec_id SHALL pop each granted non-empty queue independently; there is no error for multi-hot.
REQ-022 A simultaneous push and pop on the same queue SHALL leave occupancy unchanged, and FIFO order SHALL be preserved.
REQ-023 occupancy[i] SHALL be the registered count, with +1 on push, -1 on pop, and no change on both; it is never above DEPTH.
REQ-024 Push-to-candidate latency SHALL be 1 cycle (registered storage).

Reset
REQ-025 While rst is high: pointers SHALL reset to 0, occupancy to 0, valid_candidate to 0, candidate to '0, err_pop_empty to 0, and in_ready to 0.
REQ-026 The cycle after rst deasserts, in_ready SHALL be all ones; storage contents are not reset.
REQ-027 An rst asserted mid-traffic SHALL discard all queued entries; pushes and pops in the reset cycle have no effect.

Configuration
REQ-028 With ARB_IN_BUF_BYPASS_EN defined, when queue i is empty and in_valid[i] is high, valid_candidate[i] and candidate[i] SHALL be driven combinationally from in_valid[i]/in_data[i] (0-cycle latency).
REQ-029 Under bypass, if the bypassed entry is popped the same cycle it SHALL NOT be written; otherwise it is written normally.
REQ-030 Without ARB_IN_BUF_BYPASS_EN, REQ-024 latency SHALL apply and there SHALL be no combinational in_* to candidate path.

Structure
REQ-031 Package arb_in_buf_pkg SHALL hold the default NUM_CLIENTS, DATA_WIDTH, and DEPTH constants, and the t_client_data typedef (logic [DATA_WIDTH-1:0]).
REQ-032 Sub-module arb_in_fifo (single-client FIFO with count and error flag) SHALL be instantiated NUM_CLIENTS times via a generate loop; the top level only slices the buses.

Verification
REQ-033 Verification SHALL cover basic flow: push 0xA1 on client 2, no grant -> next cycle valid_candidate=4'b0100, candidate[2]=0xA1, occupancy[2]=1.
REQ-034 Verification SHALL cover fill: push 4 words 0x10..0x13 on client 0 -> in_ready[0]=0 after the 4th; a 5th push is dropped; grants pop 0x10,0x11,0x12,0x13 in order.
REQ-035 Verification SHALL cover full with simultaneous push and pop: client 1 is full, winner_dec_id=4'b0010 with in_valid[1]=1 -> push rejected, occupancy[1]=3, in_ready[1]=1 next cycle.
REQ-036 Verification SHALL cover pop when empty: winner_dec_id=4'b1000 with queue 3 empty -> no pointer change, err_pop_empty=4'b1000 held until rst.
REQ-037 Verification SHALL cover wrap-around: 10 push/pop pairs on client 0 with data 0..9 -> outputs 0..9 in order, occupancy never above 1, no error.
REQ-038 Verification SHALL cover mid-traffic reset: rst asserted with queues holding 2/0/3/1 entries -> next cycle all valid_candidate=0 and occupancy=0; after release, in_ready=4'b1111.
